// File: rtl/stage3_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage3_lsu_pkg
// Purpose  : Shared types and helpers for the stage3 load/store unit.
//            Provides the FSM state type, access size encodings, and the
//            crossing, misalignment and byte-lane mask helpers.
// Revision : 1.0 - initial release
// ============================================================================
package stage3_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_DONE  = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   // A dword request on a 32-bit datapath degrades to a word access
   function automatic logic [1:0] lsu_eff_size(input logic [1:0] size, input logic wide);
      return (!wide && (size == SIZE_D)) ? SIZE_W : size;
   endfunction

   // Address is not a multiple of the access length
   function automatic logic lsu_misaligned(input logic [2:0] off, input logic [1:0] size);
      logic [2:0] m;
      m = 3'((4'd1 << size) - 4'd1);
      return (off & m) != 3'd0;
   endfunction

   // Access runs past the end of the current bus word
   function automatic logic lsu_crossing(input logic [2:0] off, input logic [1:0] size,
                                         input int bytes);
      return ({1'b0, off} + (4'd1 << size)) > 4'(bytes);
   endfunction

   // Lane mask across two consecutive bus words: low half is beat 0, high half beat 1
   function automatic logic [15:0] lsu_be_mask(input logic [2:0] off, input logic [1:0] size);
      logic [15:0] m;
      m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stage3_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : stage3_lsu_align
// Purpose  : Combinational data alignment for the load/store unit. Positions
//            store data onto byte lanes across two bus words and merges two
//            load beats into an LSB-aligned, sign/zero-extended result.
// Revision : 1.0 - initial release
// ============================================================================
module stage3_lsu_align
   import stage3_lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [OFF_W-1:0]    off,
   input  logic [1:0]          size,
   input  logic                is_unsigned,
   input  logic [DATA_W-1:0]   st_data,
   output logic [2*DATA_W-1:0] st_lanes,
   input  logic [DATA_W-1:0]   ld_lo,
   input  logic [DATA_W-1:0]   ld_hi,
   output logic [DATA_W-1:0]   ld_data
);

   logic [OFF_W+2:0]  w_shamt;
   logic [DATA_W-1:0] w_ld_sh;
   logic [DATA_W-1:0] w_word;
   logic              w_sx;

   assign w_shamt  = {off, 3'b000};
   assign w_sx     = ~is_unsigned;
   assign st_lanes = {{DATA_W{1'b0}}, st_data} << w_shamt;
   // Beats are concatenated in address order so a plain right shift realigns the access
   assign w_ld_sh  = DATA_W'({ld_hi, ld_lo} >> w_shamt);

   generate
      if (DATA_W == 64) begin : g_word_ext
         assign w_word = {{32{w_sx & w_ld_sh[31]}}, w_ld_sh[31:0]};
      end else begin : g_word_full
         assign w_word = w_ld_sh;
      end
   endgenerate

   // Extend the realigned load according to access size and signedness
   always_comb begin
      ld_data = w_ld_sh;
      case (size)
         SIZE_B:  ld_data = {{(DATA_W-8){w_sx & w_ld_sh[7]}}, w_ld_sh[7:0]};
         SIZE_H:  ld_data = {{(DATA_W-16){w_sx & w_ld_sh[15]}}, w_ld_sh[15:0]};
         SIZE_W:  ld_data = w_word;
         default: ld_data = w_ld_sh;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/stage3_lsu.sv
`default_nettype none
// ============================================================================
// Module   : stage3_lsu
// Purpose  : Sequenced load/store bus master for the stage3 memory stage.
//            Issues one or two aligned bus beats per access (or traps on
//            misalignment), merges load data and reports stall/exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module stage3_lsu
   import stage3_lsu_pkg::*;
#(
   parameter int    DATA_W         = 32,
   parameter int    ADDR_W         = 32,
   parameter string MISALIGN_MODE  = "split",
   parameter string BUS_ENDIANNESS = "little"
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                req_valid,
   input  logic                req_ren,
   input  logic                req_wen,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                kill,
   output logic                lsu_stall,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                mal_l,
   output logic                mal_s,
   output logic                fault_l,
   output logic                fault_s,
   output logic [ADDR_W-1:0]   fault_addr,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic                bus_ren,
   output logic                bus_wen,
   output logic [DATA_W/8-1:0] bus_byte_en,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_busy,
   input  logic                bus_error
);

   localparam int c_BYTES = DATA_W / 8;
   localparam int c_OFF_W = $clog2(c_BYTES);
   localparam int c_BE2   = 2 * c_BYTES;
   localparam bit c_TRAP  = (MISALIGN_MODE == "trap");
   localparam bit c_BIG   = (BUS_ENDIANNESS == "big");
   localparam bit c_WIDE  = (DATA_W == 64);

   lsu_state_t          r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic                r_is_load;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_kill_seen;
   logic [DATA_W-1:0]   r_rd0;
   logic [c_BYTES-1:0]  r_be;
   logic [DATA_W-1:0]   r_wdata_le;

   logic                w_idle;
   logic                w_accept;
   logic [1:0]          w_req_size;
   logic [ADDR_W-1:0]   w_cur_addr;
   logic [1:0]          w_cur_size;
   logic [DATA_W-1:0]   w_cur_wdata;
   logic [c_OFF_W-1:0]  w_off;
   logic [ADDR_W-1:0]   w_base;
   logic [c_BE2-1:0]    w_mask;
   logic                w_cross;
   logic                w_misal;
   logic                w_kill_now;
   logic [DATA_W-1:0]   w_rdata_le;
   logic [DATA_W-1:0]   w_ld_lo;
   logic [DATA_W-1:0]   w_ld_hi;
   logic [DATA_W-1:0]   w_ld_data;
   logic [2*DATA_W-1:0] w_st_lanes;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_accept   = w_idle & req_valid & (req_ren | req_wen) & ~kill;
   assign w_req_size = lsu_eff_size(req_size, c_WIDE);

   // In IDLE the live request drives the beat-0 setup; afterwards the latched copy does
   assign w_cur_addr  = w_idle ? req_addr  : r_addr;
   assign w_cur_size  = w_idle ? w_req_size : r_size;
   assign w_cur_wdata = w_idle ? req_wdata : r_wdata;

   assign w_off      = w_cur_addr[c_OFF_W-1:0];
   assign w_base     = {w_cur_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
   assign w_mask     = c_BE2'(lsu_be_mask(3'(w_off), w_cur_size));
   assign w_cross    = lsu_crossing(3'(w_off), w_cur_size, c_BYTES);
   assign w_misal    = lsu_misaligned(3'(w_off), w_cur_size);
   assign w_kill_now = kill | r_kill_seen;

   assign w_ld_lo = (r_state == ST_BEAT1) ? r_rd0      : w_rdata_le;
   assign w_ld_hi = (r_state == ST_BEAT1) ? w_rdata_le : '0;

   assign lsu_stall = req_valid & (req_ren | req_wen) & (r_state != ST_DONE)
                    & ~(w_idle & kill);

   stage3_lsu_align #(
      .DATA_W (DATA_W),
      .OFF_W  (c_OFF_W)
   ) u_align (
      .off         (w_off),
      .size        (w_cur_size),
      .is_unsigned (r_unsigned),
      .st_data     (w_cur_wdata),
      .st_lanes    (w_st_lanes),
      .ld_lo       (w_ld_lo),
      .ld_hi       (w_ld_hi),
      .ld_data     (w_ld_data)
   );

   // Byte ordering is only changed at the bus pins; everything inside is little-endian
   generate
      if (c_BIG) begin : g_big_endian
         for (genvar i = 0; i < c_BYTES; i++) begin : g_lane
            assign bus_byte_en[i]        = r_be[c_BYTES-1-i];
            assign bus_wdata[8*i +: 8]   = r_wdata_le[8*(c_BYTES-1-i) +: 8];
            assign w_rdata_le[8*i +: 8]  = bus_rdata[8*(c_BYTES-1-i) +: 8];
         end
      end else begin : g_little_endian
         assign bus_byte_en = r_be;
         assign bus_wdata   = r_wdata_le;
         assign w_rdata_le  = bus_rdata;
      end
   endgenerate

   // Access sequencer: latch request, run one or two bus beats, pulse the response
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_size      <= SIZE_B;
         r_unsigned  <= 1'b0;
         r_is_load   <= 1'b0;
         r_wdata     <= '0;
         r_kill_seen <= 1'b0;
         r_rd0       <= '0;
         r_be        <= '0;
         r_wdata_le  <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         mal_l       <= 1'b0;
         mal_s       <= 1'b0;
         fault_l     <= 1'b0;
         fault_s     <= 1'b0;
         fault_addr  <= '0;
         bus_addr    <= '0;
         bus_ren     <= 1'b0;
         bus_wen     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr      <= req_addr;
                  r_size      <= w_req_size;
                  r_unsigned  <= req_unsigned;
                  r_is_load   <= req_ren;
                  r_wdata     <= req_wdata;
                  r_kill_seen <= 1'b0;
                  r_rd0       <= '0;
                  if (c_TRAP && w_misal) begin
                     r_state    <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     mal_l      <= req_ren;
                     mal_s      <= ~req_ren;
                     fault_addr <= req_addr;
                  end else begin
                     r_state    <= ST_BEAT0;
                     bus_addr   <= w_base;
                     bus_ren    <= req_ren;
                     bus_wen    <= ~req_ren;
                     r_be       <= w_mask[c_BYTES-1:0];
                     r_wdata_le <= w_st_lanes[DATA_W-1:0];
                  end
               end
            end

            ST_BEAT0: begin
               r_kill_seen <= r_kill_seen | kill;
               if (!bus_busy) begin
                  r_rd0 <= w_rdata_le;
                  if (bus_error) begin
                     r_state    <= ST_DONE;
                     bus_ren    <= 1'b0;
                     bus_wen    <= 1'b0;
                     r_be       <= '0;
                     r_wdata_le <= '0;
                     resp_valid <= ~w_kill_now;
                     fault_l    <= ~w_kill_now & r_is_load;
                     fault_s    <= ~w_kill_now & ~r_is_load;
                     fault_addr <= r_addr;
                  end else if (w_cross && !w_kill_now) begin
                     r_state    <= ST_BEAT1;
                     bus_addr   <= w_base + ADDR_W'(c_BYTES);
                     r_be       <= w_mask[c_BE2-1:c_BYTES];
                     r_wdata_le <= w_st_lanes[2*DATA_W-1:DATA_W];
                  end else begin
                     r_state    <= ST_DONE;
                     bus_ren    <= 1'b0;
                     bus_wen    <= 1'b0;
                     r_be       <= '0;
                     r_wdata_le <= '0;
                     resp_valid <= ~w_kill_now;
                     resp_rdata <= r_is_load ? w_ld_data : '0;
                  end
               end
            end

            ST_BEAT1: begin
               r_kill_seen <= r_kill_seen | kill;
               if (!bus_busy) begin
                  r_state    <= ST_DONE;
                  bus_ren    <= 1'b0;
                  bus_wen    <= 1'b0;
                  r_be       <= '0;
                  r_wdata_le <= '0;
                  resp_valid <= ~w_kill_now;
                  resp_rdata <= r_is_load ? w_ld_data : '0;
                  if (bus_error) begin
                     fault_l    <= ~w_kill_now & r_is_load;
                     fault_s    <= ~w_kill_now & ~r_is_load;
                     fault_addr <= w_base + ADDR_W'(c_BYTES);
                  end
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               resp_valid <= 1'b0;
               mal_l      <= 1'b0;
               mal_s      <= 1'b0;
               fault_l    <= 1'b0;
               fault_s    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stage3_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage3_lsu
// Purpose  : Self-checking bench for stage3_lsu (32-bit, little-endian):
//            table of single/split accesses plus hand-written corner cases
//            (faults, wait states, kill, async reset, trap mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage3_lsu;

   logic        CLK;
   logic        RST;
   logic        req_valid, t_req_valid;
   logic        req_ren, req_wen, req_unsigned, kill;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] bus_rdata;
   logic        bus_busy, bus_error;

   logic        lsu_stall, resp_valid, mal_l, mal_s, fault_l, fault_s;
   logic [31:0] resp_rdata, fault_addr, bus_addr, bus_wdata;
   logic        bus_ren, bus_wen;
   logic [3:0]  bus_byte_en;

   logic        t_lsu_stall, t_resp_valid, t_mal_l, t_mal_s, t_fault_l, t_fault_s;
   logic [31:0] t_resp_rdata, t_fault_addr, t_bus_addr, t_bus_wdata;
   logic        t_bus_ren, t_bus_wen;
   logic [3:0]  t_bus_byte_en;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        ren, wen;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata, rd0, rd1;
      logic        split;
      logic [3:0]  be0, be1;
      logic [31:0] a0, a1, wd0, wd1, rdata;
   } vec_t;

   vec_t vecs [13];

   stage3_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_MODE("split"), .BUS_ENDIANNESS("little")) u_dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .kill(kill), .lsu_stall(lsu_stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mal_l(mal_l), .mal_s(mal_s), .fault_l(fault_l), .fault_s(fault_s), .fault_addr(fault_addr),
      .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_byte_en(bus_byte_en),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_error(bus_error)
   );

   stage3_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_MODE("trap"), .BUS_ENDIANNESS("little")) u_trap (
      .CLK(CLK), .RST(RST), .req_valid(t_req_valid), .req_ren(req_ren), .req_wen(req_wen),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .kill(kill), .lsu_stall(t_lsu_stall), .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata),
      .mal_l(t_mal_l), .mal_s(t_mal_s), .fault_l(t_fault_l), .fault_s(t_fault_s), .fault_addr(t_fault_addr),
      .bus_addr(t_bus_addr), .bus_ren(t_bus_ren), .bus_wen(t_bus_wen), .bus_byte_en(t_bus_byte_en),
      .bus_wdata(t_bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_error(bus_error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   task automatic set_req(input logic ren, input logic wen, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      req_ren = ren; req_wen = wen; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
   endtask

   task automatic drop_req();
      req_valid = 1'b0; t_req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge CLK);
      set_req(v.ren, v.wen, v.size, v.uns, v.addr, v.wdata);
      req_valid = 1'b1; bus_busy = 1'b0; bus_error = 1'b0; bus_rdata = '0;
      #1 chk($sformatf("v%0d_stall_accept", idx), lsu_stall, 1);
      @(negedge CLK);
      chk($sformatf("v%0d_ren0", idx), bus_ren, v.ren);
      chk($sformatf("v%0d_wen0", idx), bus_wen, !v.ren);
      chk($sformatf("v%0d_addr0", idx), bus_addr, v.a0);
      chk($sformatf("v%0d_be0", idx), bus_byte_en, v.be0);
      if (!v.ren) chk($sformatf("v%0d_wd0", idx), bus_wdata & lanes(v.be0), v.wd0 & lanes(v.be0));
      chk($sformatf("v%0d_stall_beat0", idx), lsu_stall, 1);
      chk($sformatf("v%0d_early_resp", idx), resp_valid, 0);
      bus_rdata = v.rd0;
      @(negedge CLK);
      if (v.split) begin
         chk($sformatf("v%0d_addr1", idx), bus_addr, v.a1);
         chk($sformatf("v%0d_be1", idx), bus_byte_en, v.be1);
         if (!v.ren) chk($sformatf("v%0d_wd1", idx), bus_wdata & lanes(v.be1), v.wd1 & lanes(v.be1));
         chk($sformatf("v%0d_early_resp1", idx), resp_valid, 0);
         bus_rdata = v.rd1;
         @(negedge CLK);
      end
      chk($sformatf("v%0d_resp_valid", idx), resp_valid, 1);
      chk($sformatf("v%0d_stall_done", idx), lsu_stall, 0);
      chk($sformatf("v%0d_strobes_off", idx), {bus_ren, bus_wen}, 2'b00);
      chk($sformatf("v%0d_faults", idx), {fault_l, fault_s, mal_l, mal_s}, 4'b0000);
      if (v.ren) chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
      drop_req();
      @(negedge CLK);
      chk($sformatf("v%0d_resp_pulse", idx), resp_valid, 0);
   endtask

   initial begin
      // ren wen size uns addr wdata rd0 rd1 split be0 be1 a0 a1 wd0 wd1 rdata
      vecs[0]  = '{1, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF};
      vecs[1]  = '{1, 0, 2'd0, 0, 32'h103, 0, 32'h80123456, 0, 0, 4'b1000, 0, 32'h100, 0, 0, 0, 32'hFFFFFF80};
      vecs[2]  = '{1, 0, 2'd0, 1, 32'h103, 0, 32'h80123456, 0, 0, 4'b1000, 0, 32'h100, 0, 0, 0, 32'h00000080};
      vecs[3]  = '{1, 0, 2'd2, 0, 32'h102, 0, 32'h33445566, 32'h77881122, 1, 4'b1100, 4'b0011,
                   32'h100, 32'h104, 0, 0, 32'h11223344};
      vecs[4]  = '{1, 0, 2'd1, 0, 32'h102, 0, 32'h80010000, 0, 0, 4'b1100, 0, 32'h100, 0, 0, 0, 32'hFFFF8001};
      vecs[5]  = '{1, 0, 2'd1, 0, 32'h101, 0, 32'h00ABCD00, 0, 0, 4'b0110, 0, 32'h100, 0, 0, 0, 32'hFFFFABCD};
      vecs[6]  = '{1, 0, 2'd1, 0, 32'h103, 0, 32'h12000000, 32'h000000FE, 1, 4'b1000, 4'b0001,
                   32'h100, 32'h104, 0, 0, 32'hFFFFFE12};
      vecs[7]  = '{0, 1, 2'd2, 0, 32'h103, 32'hAABBCCDD, 0, 0, 1, 4'b1000, 4'b0111,
                   32'h100, 32'h104, 32'hDD000000, 32'h00AABBCC, 0};
      vecs[8]  = '{0, 1, 2'd0, 0, 32'h101, 32'h000000A5, 0, 0, 0, 4'b0010, 0, 32'h100, 0, 32'h0000A500, 0, 0};
      vecs[9]  = '{0, 1, 2'd1, 0, 32'h100, 32'h00001234, 0, 0, 0, 4'b0011, 0, 32'h100, 0, 32'h00001234, 0, 0};
      vecs[10] = '{1, 1, 2'd2, 0, 32'h108, 32'h55555555, 32'hCAFEF00D, 0, 0, 4'b1111, 0, 32'h108, 0, 0, 0, 32'hCAFEF00D};
      vecs[11] = '{1, 0, 2'd3, 0, 32'h10C, 0, 32'h80000001, 0, 0, 4'b1111, 0, 32'h10C, 0, 0, 0, 32'h80000001};
      vecs[12] = '{1, 0, 2'd1, 1, 32'h102, 0, 32'h80010000, 0, 0, 4'b1100, 0, 32'h100, 0, 0, 0, 32'h00008001};

      RST = 1'b1; kill = 1'b0; bus_busy = 1'b0; bus_error = 1'b0; bus_rdata = '0;
      drop_req(); set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_strobes", {bus_ren, bus_wen}, 2'b00);
      chk("rst_byte_en", bus_byte_en, 4'b0000);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_fault_addr", fault_addr, 0);
      chk("rst_stall", lsu_stall, 0);
      chk("rst_trap_resp", t_resp_valid, 0);

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // Split store with bus error on the second beat
      @(negedge CLK);
      set_req(0, 1, 2'd2, 0, 32'h103, 32'hAABBCCDD); req_valid = 1'b1;
      @(negedge CLK);
      chk("err1_beat0_wen", bus_wen, 1);
      @(negedge CLK);
      chk("err1_beat1_addr", bus_addr, 32'h104);
      bus_error = 1'b1;
      @(negedge CLK);
      chk("err1_resp_valid", resp_valid, 1);
      chk("err1_fault_s", fault_s, 1);
      chk("err1_fault_l", fault_l, 0);
      chk("err1_fault_addr", fault_addr, 32'h104);
      bus_error = 1'b0; drop_req();
      @(negedge CLK);
      chk("err1_fault_clear", fault_s, 0);

      // Split load with bus error on the first beat: no second beat
      @(negedge CLK);
      set_req(1, 0, 2'd2, 0, 32'h102, 0); req_valid = 1'b1;
      @(negedge CLK);
      bus_error = 1'b1;
      @(negedge CLK);
      chk("err0_resp_valid", resp_valid, 1);
      chk("err0_fault_l", fault_l, 1);
      chk("err0_fault_addr", fault_addr, 32'h102);
      chk("err0_no_beat1", bus_ren, 0);
      bus_error = 1'b0; drop_req();

      // Aligned load with one wait cycle: response one cycle later
      @(negedge CLK);
      set_req(1, 0, 2'd2, 0, 32'h104, 0); req_valid = 1'b1; bus_busy = 1'b1;
      @(negedge CLK);
      chk("wait_ren_c1", bus_ren, 1);
      @(negedge CLK);
      chk("wait_ren_c2", bus_ren, 1);
      chk("wait_no_resp", resp_valid, 0);
      bus_busy = 1'b0; bus_rdata = 32'h0BADF00D;
      @(negedge CLK);
      chk("wait_resp_valid", resp_valid, 1);
      chk("wait_rdata", resp_rdata, 32'h0BADF00D);
      drop_req();

      // Kill while idle: no stall, no bus traffic
      @(negedge CLK);
      set_req(1, 0, 2'd2, 0, 32'h100, 0); req_valid = 1'b1; kill = 1'b1;
      #1 chk("kill_idle_stall", lsu_stall, 0);
      @(negedge CLK);
      chk("kill_idle_no_ren", bus_ren, 0);
      kill = 1'b0; drop_req();

      // Kill during beat 0 of a split load with the bus busy for three cycles
      @(negedge CLK);
      set_req(1, 0, 2'd2, 0, 32'h102, 0); req_valid = 1'b1; bus_busy = 1'b1;
      @(negedge CLK);
      chk("kill_ren_c1", bus_ren, 1);
      kill = 1'b1;
      @(negedge CLK);
      chk("kill_ren_c2", bus_ren, 1);
      kill = 1'b0;
      @(negedge CLK);
      chk("kill_ren_c3", bus_ren, 1);
      bus_busy = 1'b0;
      @(negedge CLK);
      chk("kill_no_resp", resp_valid, 0);
      chk("kill_no_beat1", bus_ren, 0);
      drop_req();
      @(negedge CLK);
      chk("kill_still_no_resp", resp_valid, 0);
      chk("kill_idle_ren", bus_ren, 0);

      // Asynchronous reset in the middle of beat 1
      @(negedge CLK);
      set_req(1, 0, 2'd2, 0, 32'h102, 0); req_valid = 1'b1; bus_busy = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_mid_beat1_ren", bus_ren, 1);
      chk("rst_mid_beat1_addr", bus_addr, 32'h104);
      bus_busy = 1'b1;
      #2 RST = 1'b1;
      #1 chk("rst_async_ren", bus_ren, 0);
      chk("rst_async_addr", bus_addr, 0);
      @(negedge CLK);
      RST = 1'b0; drop_req(); bus_busy = 1'b0;
      @(negedge CLK);
      chk("rst_async_no_resp", resp_valid, 0);

      // Trap mode: misaligned load
      @(negedge CLK);
      set_req(1, 0, 2'd1, 0, 32'h101, 0); t_req_valid = 1'b1;
      #1 chk("trap_l_stall", t_lsu_stall, 1);
      @(negedge CLK);
      chk("trap_l_resp_valid", t_resp_valid, 1);
      chk("trap_l_mal", {t_mal_l, t_mal_s}, 2'b10);
      chk("trap_l_fault_addr", t_fault_addr, 32'h101);
      chk("trap_l_no_strobe", {t_bus_ren, t_bus_wen}, 2'b00);
      chk("trap_l_stall_done", t_lsu_stall, 0);
      drop_req();
      @(negedge CLK);
      chk("trap_l_pulse", t_resp_valid, 0);

      // Trap mode: misaligned store
      @(negedge CLK);
      set_req(0, 1, 2'd2, 0, 32'h102, 32'h12345678); t_req_valid = 1'b1;
      @(negedge CLK);
      chk("trap_s_mal", {t_mal_l, t_mal_s}, 2'b01);
      chk("trap_s_fault_addr", t_fault_addr, 32'h102);
      chk("trap_s_no_strobe", {t_bus_ren, t_bus_wen}, 2'b00);
      drop_req();
      @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
